// File: rtl/cfo_correction_nco.sv
// CFO correction NCO: turns CFO estimates into a phase increment and
// derotates the IQ stream through a quarter-wave sin/cos LUT.
module cfo_correction_nco #(
  parameter int IN_DW     = 32,
  parameter int CFO_DW    = 20,
  parameter int PHASE_DW  = 24,
  parameter int DIST_LOG2 = 7,
  parameter int LUT_AW    = 10,
  parameter int LUT_DW    = 16,
  parameter int ACCUM     = 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [IN_DW-1:0]    s_axis_in_tdata,
  input  logic                s_axis_in_tvalid,
  input  logic [CFO_DW-1:0]   CFO_norm_i,
  input  logic                CFO_valid_i,
  input  logic                phase_reset_i,
  output logic [IN_DW-1:0]    m_axis_out_tdata,
  output logic                m_axis_out_tvalid,
  output logic [PHASE_DW-1:0] phase_inc_o
);

  localparam int HW    = IN_DW / 2;
  localparam int LUT_N = 1 << LUT_AW;
  localparam int IDX_W = LUT_AW + 2;
  localparam int MW    = HW + LUT_DW + 1;

  function automatic logic signed [LUT_DW-1:0] lut_entry(input int i);
    real amp;
    real x;
    amp = real'((1 << (LUT_DW - 1)) - 1);
    x = amp * $sin(real'(i) * 3.14159265358979323846
                   / 2.0 / real'(LUT_N));
    return LUT_DW'($rtoi(x + 0.5));
  endfunction

  function automatic logic [HW-1:0] round_sat(
    input logic signed [MW-1:0] v
  );
    logic signed [MW-1:0] r;
    logic signed [MW-1:0] hi;
    logic signed [MW-1:0] lo;
    hi = MW'((1 << (HW - 1)) - 1);
    lo = -hi - MW'(1);
    r  = (v + MW'(1 << (LUT_DW - 2))) >>> (LUT_DW - 1);
    if (r > hi)      return HW'(hi);
    else if (r < lo) return HW'(lo);
    else             return HW'(r);
  endfunction

  // Quarter-wave table, entries 0..LUT_N so cos(0) reads the peak.
  logic signed [LUT_DW-1:0] lut [0:LUT_N];
  for (genvar g = 0; g <= LUT_N; g++) begin : g_lut
    localparam logic signed [LUT_DW-1:0] V = lut_entry(g);
    assign lut[g] = V;
  end

  logic signed [PHASE_DW-1:0] cfo_ext;
  logic signed [PHASE_DW-1:0] cfo_scl;
  logic signed [PHASE_DW-1:0] delta;
  assign cfo_ext = PHASE_DW'($signed(CFO_norm_i));
  assign cfo_scl = cfo_ext <<< (PHASE_DW - CFO_DW);
  assign delta   = cfo_scl >>> DIST_LOG2;

  logic [PHASE_DW-1:0] acc_q, acc_d;
  logic [PHASE_DW-1:0] inc_q, inc_d;
  logic [PHASE_DW-1:0] phase_k;

  // Phase accumulator and increment next-state.
  always_comb begin
    phase_k = phase_reset_i ? '0 : acc_q;
    acc_d   = acc_q;
    inc_d   = inc_q;
    if (s_axis_in_tvalid) acc_d = phase_k + inc_q;
    else if (phase_reset_i) acc_d = '0;
    if (CFO_valid_i) begin
      if (ACCUM != 0) inc_d = inc_q + delta;
      else            inc_d = delta;
    end
  end

  logic                     s1_v_q;
  logic signed [HW-1:0]     s1_re_q, s1_im_q;
  logic [IDX_W-1:0]         s1_idx_q;
  logic                     s2_v_q;
  logic signed [HW-1:0]     s2_re_q, s2_im_q;
  logic signed [LUT_DW-1:0] s2_sin_q, s2_cos_q;
  logic                     s3_v_q;
  logic signed [MW-1:0]     s3_re_q, s3_im_q;
  logic [IN_DW-1:0]         out_q;
  logic                     out_v_q;

  logic [1:0]               quad;
  logic [LUT_AW:0]          a_idx, m_idx;
  logic signed [LUT_DW-1:0] sb, cb;
  logic signed [LUT_DW-1:0] sin_d, cos_d;
  logic signed [MW-1:0]     mre_d, mim_d;

  // Quadrant folding of the registered phase index.
  always_comb begin
    quad  = s1_idx_q[IDX_W-1 -: 2];
    a_idx = {1'b0, s1_idx_q[LUT_AW-1:0]};
    m_idx = (LUT_AW+1)'(LUT_N) - a_idx;
    sb    = lut[a_idx];
    cb    = lut[m_idx];
    unique case (quad)
      2'd0:    begin sin_d = sb;  cos_d = cb;  end
      2'd1:    begin sin_d = cb;  cos_d = -sb; end
      2'd2:    begin sin_d = -sb; cos_d = -cb; end
      default: begin sin_d = -cb; cos_d = sb;  end
    endcase
  end

  // Full-precision complex multiply.
  always_comb begin
    mre_d = s2_re_q * s2_cos_q - s2_im_q * s2_sin_q;
    mim_d = s2_re_q * s2_sin_q + s2_im_q * s2_cos_q;
  end

  // Four-stage pipeline: accept, LUT, multiply, round/saturate.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q    <= '0;
      inc_q    <= '0;
      s1_v_q   <= 1'b0;
      s1_re_q  <= '0;
      s1_im_q  <= '0;
      s1_idx_q <= '0;
      s2_v_q   <= 1'b0;
      s2_re_q  <= '0;
      s2_im_q  <= '0;
      s2_sin_q <= '0;
      s2_cos_q <= '0;
      s3_v_q   <= 1'b0;
      s3_re_q  <= '0;
      s3_im_q  <= '0;
      out_q    <= '0;
      out_v_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      inc_q    <= inc_d;
      s1_v_q   <= s_axis_in_tvalid;
      s1_re_q  <= s_axis_in_tdata[HW-1:0];
      s1_im_q  <= s_axis_in_tdata[IN_DW-1:HW];
      s1_idx_q <= phase_k[PHASE_DW-1 -: IDX_W];
      s2_v_q   <= s1_v_q;
      s2_re_q  <= s1_re_q;
      s2_im_q  <= s1_im_q;
      s2_sin_q <= sin_d;
      s2_cos_q <= cos_d;
      s3_v_q   <= s2_v_q;
      s3_re_q  <= mre_d;
      s3_im_q  <= mim_d;
      out_v_q  <= s3_v_q;
      if (s3_v_q)
        out_q <= {round_sat(s3_im_q), round_sat(s3_re_q)};
    end
  end

  assign m_axis_out_tdata  = out_q;
  assign m_axis_out_tvalid = out_v_q;
  assign phase_inc_o       = inc_q;

endmodule

// File: doc/cfo_correction_nco.md
Name: cfo_correction_nco

Overview:
- Streaming CFO corrector placed downstream of the CFO estimator.
- Converts each normalized CFO estimate (signed angle, full scale ±pi, measured over 2^DIST_LOG2 samples) into a per-sample phase increment.
- Accumulates phase over accepted samples and derotates the baseband IQ stream with a quarter-wave sin/cos LUT and a complex multiplier.
- Output feeds the FFT/demodulation path; no backpressure.

Parameters:
- IN_DW, 32, packed IQ width: {imag[IN_DW-1:IN_DW/2], real[IN_DW/2-1:0]}, signed two's complement.
- CFO_DW, 20, width of the CFO estimate; 2^(CFO_DW-1) represents pi.
- PHASE_DW, 24, phase accumulator width; 2^PHASE_DW represents 2pi. Must be >= CFO_DW.
- DIST_LOG2, 7, log2 of the sample distance the CFO angle was measured over.
- LUT_AW, 10, quarter-wave LUT address width.
- LUT_DW, 16, signed sin/cos width; peak value 2^(LUT_DW-1)-1.
- ACCUM, 1: 1 = new estimate is a residual and is added to the increment; 0 = new estimate replaces the increment.

Ports:
- clk_i, input, 1: clock.
- reset_i, input, 1: asynchronous, active-high reset.
- s_axis_in_tdata, input, IN_DW: input IQ sample.
- s_axis_in_tvalid, input, 1: sample valid; the sample is accepted every cycle it is high.
- CFO_norm_i, input, CFO_DW: signed CFO angle estimate.
- CFO_valid_i, input, 1: one-cycle strobe qualifying CFO_norm_i.
- phase_reset_i, input, 1: clears the phase accumulator.
- m_axis_out_tdata, output, IN_DW: derotated IQ, same packing as input.
- m_axis_out_tvalid, output, 1: output valid.
- phase_inc_o, output, PHASE_DW: current phase increment (signed), for debug/status.

Behaviour:
- Reset (asynchronous, active-high):
  - Phase accumulator, increment, all pipeline valids, m_axis_out_tdata, m_axis_out_tvalid and phase_inc_o go to 0.
  - In-flight samples are discarded; no tvalid is produced for them.
- Increment computation:
  - delta = (sign-extend CFO_norm_i to PHASE_DW) << (PHASE_DW-CFO_DW), then arithmetic shift right by DIST_LOG2.
  - ACCUM=1: inc <= inc + delta, wrapping modulo 2^PHASE_DW. ACCUM=0: inc <= delta.
  - A strobe at cycle t is visible on phase_inc_o at t+1. It affects phase advances for samples accepted at t+1 and later.
- Phase:
  - Sample k is rotated by exp(+j*phase_k), where phase_k is the accumulator value at acceptance.
  - After acceptance the accumulator becomes phase_k + inc, wrapping.
  - The accumulator advances only on accepted samples.
- phase_reset_i:
  - At cycle t with a sample accepted: that sample uses phase 0, and the accumulator becomes inc.
  - At cycle t with no sample: the accumulator becomes 0.
  - phase_reset_i does not touch inc.
  - Coincident CFO_valid_i: the sample at t still uses the old inc.
- Sign convention: CFO_norm = angle(C0*conj(C1)), with C0 the earlier half. A positive residual frequency gives a negative CFO_norm, so rotating by +phase removes it.
- Sin/cos lookup:
  - Index = top (LUT_AW+2) bits of the phase; the remaining bits are truncated.
  - The top 2 bits select the quadrant; the LUT covers 0..pi/2.
  - Entry i = round((2^(LUT_DW-1)-1) * sin(i*pi/2 / 2^LUT_AW)). cos is read by mirrored index.
- Complex multiply:
  - out_re = re*cos - im*sin; out_im = re*sin + im*cos, at full precision.
  - Add 2^(LUT_DW-2), then arithmetic shift right by LUT_DW-1.
  - Saturate each component to signed IN_DW/2; never wrap.
- Pipeline: fixed 4 cycles (accept/phase, LUT read, multiply, round/saturate).
  - m_axis_out_tvalid equals s_axis_in_tvalid delayed by 4 cycles, preserving gaps.
  - Back-to-back samples are accepted every cycle.
  - m_axis_out_tdata holds its last value when tvalid is low.
- CFO_valid_i may arrive at any time, including while samples are in flight. Samples already accepted keep their phase.

Test Plan:
1. Zero CFO: after reset, 20 consecutive samples (re=1000, im=0) -> from 4 cycles later, 20 outputs equal to (1000, 0) ±1; a 2-cycle input gap gives a 2-cycle tvalid gap.
2. ACCUM=0, CFO_norm_i=262144 -> phase_inc_o=32768 next cycle. Feed 128 samples (1000, 0) -> output 129 (phase 2^22 = pi/2) is (0, 1000) ±2.
3. ACCUM=0, CFO_norm_i=-262144 -> phase_inc_o=0xFF8000. After 128 samples -> output (0, -1000) ±2; 256 samples -> (-1000, 0) ±2.
4. ACCUM=1, two strobes of 65536 -> phase_inc_o 8192 then 16384. A strobe coincident with a sample does not change that sample's phase.
5. Saturation: accumulator at 2^21 (pi/4), input (32767, 32767) -> output (0±2, 32767), imag saturated with no wrap.
6. Reset mid-stream with 3 samples in flight, then phase_reset_i coincident with a sample -> no tvalid for the flushed samples; phase_inc_o=0; the next sample output equals its input ±1.
